// File: rtl/shift_reg_sipo_frame_if.sv
// Serial-in / word-out bundle for shift_reg_sipo_frame.
// Port direction names are from the deserialiser's point of view.
interface shift_reg_sipo_frame_if #(
    parameter int WL = 16
);
    logic          i_en;
    logic          i_sync;
    logic          i_in;
    logic [WL-1:0] o_out;
    logic          o_vld;
    logic [3:0]    o_ch;
    logic          o_err;

    // i_en qualifies i_sync and i_in; o_vld and o_err are single-cycle strobes,
    // o_out/o_ch hold the last completed word between o_vld pulses.
    modport master (
        output i_en,
        output i_sync,
        output i_in,
        input  o_out,
        input  o_vld,
        input  o_ch,
        input  o_err
    );

    modport slave (
        input  i_en,
        input  i_sync,
        input  i_in,
        output o_out,
        output o_vld,
        output o_ch,
        output o_err
    );
endinterface

// File: rtl/shift_reg_sipo_frame.sv
// Frame-aware SIPO deserialiser: WL-bit words for NCH TDM channels, MSB/LSB first.
// Optional short-word error pulse enabled by defining SIPO_ERR_EN.
module shift_reg_sipo_frame #(
    parameter int WL        = 16,
    parameter int NCH       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    shift_reg_sipo_frame_if.slave  bus,
    output logic                   o_dbg_state
);
    localparam int BCW = $clog2(WL);
    localparam logic [BCW-1:0] BC_LAST = BCW'(WL - 1);
    localparam logic [3:0]     CC_LAST = 4'(NCH - 1);

    typedef enum logic {
        S_HUNT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [WL-1:0]  r_sr, w_sr_nxt;
    logic [BCW-1:0] r_bc, w_bc_nxt;
    logic [3:0]     r_cc, w_cc_nxt;
    logic [WL-1:0]  r_out, w_out_nxt;
    logic [3:0]     r_ch, w_ch_nxt;
    logic           r_vld, w_vld_nxt;
    logic           r_err, w_err_nxt;
    logic [WL-1:0]  w_shift;
    logic [WL-1:0]  w_first;

    function automatic logic [WL-1:0] shift_in(input logic [WL-1:0] sr, input logic b);
        if (MSB_FIRST)
            return {sr[WL-2:0], b};
        else
            return {b, sr[WL-1:1]};
    endfunction

    assign w_shift = shift_in(r_sr, bus.i_in);
    // A frame start restarts assembly from an empty register.
    assign w_first = shift_in('0, bus.i_in);

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bc_nxt    = r_bc;
        w_cc_nxt    = r_cc;
        w_out_nxt   = r_out;
        w_ch_nxt    = r_ch;
        w_vld_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        if (bus.i_en) begin
            if (bus.i_sync) begin
                w_sr_nxt    = w_first;
                w_bc_nxt    = BCW'(1);
                w_cc_nxt    = '0;
                w_state_nxt = S_RUN;
`ifdef SIPO_ERR_EN
                w_err_nxt   = (r_state == S_RUN) && (r_bc != '0);
`endif
            end else if (r_state == S_RUN) begin
                w_sr_nxt = w_shift;
                if (r_bc == BC_LAST) begin
                    w_out_nxt = w_shift;
                    w_ch_nxt  = r_cc;
                    w_vld_nxt = 1'b1;
                    w_bc_nxt  = '0;
                    w_cc_nxt  = (r_cc == CC_LAST) ? 4'd0 : r_cc + 4'd1;
                end else begin
                    w_bc_nxt = r_bc + BCW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_HUNT;
            r_sr    <= '0;
            r_bc    <= '0;
            r_cc    <= '0;
            r_out   <= '0;
            r_ch    <= '0;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_bc    <= w_bc_nxt;
            r_cc    <= w_cc_nxt;
            r_out   <= w_out_nxt;
            r_ch    <= w_ch_nxt;
            r_vld   <= w_vld_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.o_out   = r_out;
    assign bus.o_ch    = r_ch;
    assign bus.o_vld   = r_vld;
    assign bus.o_err   = r_err;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_shift_reg_sipo_frame.sv
// Randomised scoreboard bench for shift_reg_sipo_frame (16-bit MSB-first and
// 8-bit LSB-first instances) against a bit-list reference model.
module tb_shift_reg_sipo_frame;
    localparam int WL0 = 16;
    localparam int NCH0 = 2;
    localparam bit MSB0 = 1'b1;
    localparam int WL1 = 8;
    localparam int NCH1 = 3;
    localparam bit MSB1 = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_reg_sipo_frame_if #(.WL(WL0)) if0 ();
    shift_reg_sipo_frame_if #(.WL(WL1)) if1 ();
    logic dbg0, dbg1;

    shift_reg_sipo_frame #(.WL(WL0), .NCH(NCH0), .MSB_FIRST(MSB0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .bus(if0.slave), .o_dbg_state(dbg0)
    );
    shift_reg_sipo_frame #(.WL(WL1), .NCH(NCH1), .MSB_FIRST(MSB1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .bus(if1.slave), .o_dbg_state(dbg1)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Entry = {due cycle, channel, word}
    logic [67:0] exp_q0[$];
    logic [67:0] exp_q1[$];
    logic [31:0] err_q0[$];
    logic [31:0] err_q1[$];

    logic        mbits[2][32];
    int          mn[2];
    bit          mrun[2];
    int          mch[2];
    logic [31:0] last_out[2];
    logic [3:0]  last_ch[2];

    function automatic int wl_of(input int sel);
        return (sel == 0) ? WL0 : WL1;
    endfunction
    function automatic int nch_of(input int sel);
        return (sel == 0) ? NCH0 : NCH1;
    endfunction
    function automatic bit msb_of(input int sel);
        return (sel == 0) ? MSB0 : MSB1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int sel, input logic en, input logic sync, input logic b);
        int          wl;
        logic [31:0] w;
        logic [67:0] e;
        wl = wl_of(sel);
        if (!en) return;
        if (sync) begin
`ifdef SIPO_ERR_EN
            if (mrun[sel] && mn[sel] > 0) begin
                if (sel == 0) err_q0.push_back(32'(cyc + 1));
                else          err_q1.push_back(32'(cyc + 1));
            end
`endif
            mbits[sel][0] = b;
            mn[sel]   = 1;
            mch[sel]  = 0;
            mrun[sel] = 1'b1;
        end else if (mrun[sel]) begin
            mbits[sel][mn[sel]] = b;
            mn[sel]++;
            if (mn[sel] == wl) begin
                w = '0;
                for (int i = 0; i < wl; i++) begin
                    if (msb_of(sel)) w = {w[30:0], mbits[sel][i]};
                    else             w[i] = mbits[sel][i];
                end
                e = {32'(cyc + 1), 4'(mch[sel]), w};
                if (sel == 0) exp_q0.push_back(e);
                else          exp_q1.push_back(e);
                mch[sel] = (mch[sel] + 1) % nch_of(sel);
                mn[sel]  = 0;
            end
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic sync, input logic b);
        @(negedge clk);
        if (sel == 0) begin
            if0.i_en = en; if0.i_sync = sync; if0.i_in = b;
            if1.i_en = 1'b0;
        end else begin
            if1.i_en = en; if1.i_sync = sync; if1.i_in = b;
            if0.i_en = 1'b0;
        end
        model_step(sel, en, sync, b);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input int sel, input logic [31:0] w, input bit sync, input int maxgap);
        int   wl;
        logic b;
        wl = wl_of(sel);
        for (int i = 0; i < wl; i++) begin
            b = msb_of(sel) ? w[wl-1-i] : w[i];
            drive(sel, 1'b1, sync && (i == 0), b);
            if (maxgap > 0 && i < wl - 1)
                repeat ($urandom_range(0, maxgap)) drive(sel, 1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if0.i_en = 1'b0;
        if1.i_en = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mn[s] = 0; mrun[s] = 1'b0; mch[s] = 0;
            last_out[s] = '0; last_ch[s] = '0;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out0", 32'(if0.o_out), 32'h0);
        chk("rst_vld0", 32'(if0.o_vld), 32'h0);
        chk("rst_ch0",  32'(if0.o_ch), 32'h0);
        chk("rst_err0", 32'(if0.o_err), 32'h0);
        chk("rst_state0", 32'(dbg0), 32'h0);
        chk("rst_out1", 32'(if1.o_out), 32'h0);
        chk("rst_state1", 32'(dbg1), 32'h0);
    endtask

    task automatic monitor_one(input int sel, input logic vld, input logic err,
                               input logic [31:0] out, input logic [3:0] ch);
        logic [67:0] e;
        logic        exp_vld;
        logic        exp_err;
        exp_vld = 1'b0;
        exp_err = 1'b0;
        e = '0;
        if (sel == 0 && exp_q0.size() > 0 && exp_q0[0][67:36] == 32'(cyc)) begin
            exp_vld = 1'b1; e = exp_q0.pop_front();
        end
        if (sel == 1 && exp_q1.size() > 0 && exp_q1[0][67:36] == 32'(cyc)) begin
            exp_vld = 1'b1; e = exp_q1.pop_front();
        end
        if (sel == 0 && err_q0.size() > 0 && err_q0[0] == 32'(cyc)) begin
            exp_err = 1'b1; void'(err_q0.pop_front());
        end
        if (sel == 1 && err_q1.size() > 0 && err_q1[0] == 32'(cyc)) begin
            exp_err = 1'b1; void'(err_q1.pop_front());
        end
        chk($sformatf("vld%0d", sel), 32'(vld), 32'(exp_vld));
        chk($sformatf("err%0d", sel), 32'(err), 32'(exp_err));
        if (exp_vld) begin
            chk($sformatf("out%0d", sel), out, e[31:0]);
            chk($sformatf("ch%0d", sel), 32'(ch), 32'(e[35:32]));
            last_out[sel] = e[31:0];
            last_ch[sel]  = e[35:32];
        end else begin
            chk($sformatf("hold_out%0d", sel), out, last_out[sel]);
            chk($sformatf("hold_ch%0d", sel), 32'(ch), 32'(last_ch[sel]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        monitor_one(0, if0.o_vld, if0.o_err, 32'(if0.o_out), if0.o_ch);
        monitor_one(1, if1.o_vld, if1.o_err, 32'(if1.o_out), if1.o_ch);
    end

    initial begin
        int n;
        if0.i_en = 1'b0; if0.i_sync = 1'b0; if0.i_in = 1'b0;
        if1.i_en = 1'b0; if1.i_sync = 1'b0; if1.i_in = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mn[s] = 0; mrun[s] = 1'b0; mch[s] = 0;
            last_out[s] = '0; last_ch[s] = '0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        // Back-to-back channels with wrap
        send_word(0, 32'hA5C3, 1'b1, 0);
        send_word(0, 32'h1234, 1'b0, 0);
        send_word(0, 32'hFFFF, 1'b0, 0);
        idle(2);
        chk("run_state0", 32'(dbg0), 32'h1);

        // EN gaps inside a word
        send_word(0, 32'h8001, 1'b1, 3);
        idle(3);

        // HUNT discards unsynchronised bits
        do_reset();
        repeat (5) drive(0, 1'b1, 1'b0, 1'($urandom));
        chk("hunt_state0", 32'(dbg0), 32'h0);
        send_word(0, 32'h0F0F, 1'b1, 0);
        idle(2);

        // Short word aborted by SYNC
        repeat (7) drive(0, 1'b1, 1'b0, 1'($urandom));
        send_word(0, 32'h7FFF, 1'b1, 0);
        idle(2);

        // Reset in the middle of a word
        send_word(0, 32'h5A5A, 1'b1, 0);
        repeat (9) drive(0, 1'b1, 1'b0, 1'($urandom));
        do_reset();
        repeat (5) drive(0, 1'b1, 1'b0, 1'($urandom));
        idle(2);
        chk("post_rst_hunt0", 32'(dbg0), 32'h0);

        // Randomised traffic on the 16-bit instance
        send_word(0, $urandom, 1'b1, 2);
        repeat (40) begin
            case ($urandom_range(0, 5))
                0: begin
                    n = $urandom_range(1, WL0 - 1);
                    repeat (n) drive(0, 1'b1, 1'b0, 1'($urandom));
                    send_word(0, $urandom, 1'b1, 2);
                end
                1:       send_word(0, $urandom, 1'b1, 2);
                default: send_word(0, $urandom, 1'b0, $urandom_range(0, 2));
            endcase
        end
        idle(3);

        // LSB-first 8-bit instance
        send_word(1, 32'h01, 1'b1, 0);
        idle(2);
        chk("lsb_first_out1", 32'(if1.o_out), 32'h01);
        repeat (20) begin
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, WL1 - 1);
                repeat (n) drive(1, 1'b1, 1'b0, 1'($urandom));
                send_word(1, $urandom, 1'b1, 1);
            end else begin
                send_word(1, $urandom, 1'b0, $urandom_range(0, 2));
            end
        end
        idle(4);

        chk("exp_q0_drained", 32'(exp_q0.size()), 32'h0);
        chk("exp_q1_drained", 32'(exp_q1.size()), 32'h0);
        chk("err_q0_drained", 32'(err_q0.size()), 32'h0);
        chk("err_q1_drained", 32'(err_q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
